// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive control path: config FSM states,
// prescale limits and the configuration record.
package uart_pkg;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_IDLE  = 2'd1,
    S_FRAME = 2'd2,
    S_PEND  = 2'd3
  } rx_state_e;

  localparam int unsigned PRESCALE_MIN = 4;
  localparam int unsigned PRESCALE_DEF = 8;

  typedef struct packed {
    logic       en;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
  } rx_cfg_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO for received bytes. Head entry is visible on
// rd_data without a pop; a push on a full FIFO is accepted only alongside a pop.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic                     push_ok,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic [$clog2(DEPTH):0]   cnt_next
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_data = mem_q[rd_ptr_q];
  assign cnt     = cnt_q;

  always_comb begin
    cnt_next = cnt_q;
    if (push_ok && !pop_ok) begin
      cnt_next = cnt_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      cnt_next = cnt_q - CW'(1);
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control wrapper: frame-safe config updates, RX byte buffer,
// sticky error flags, frame counter and registered level interrupt.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned PRESCALE_DEF = uart_pkg::PRESCALE_DEF,
  parameter int unsigned IRQ_THRESH   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_wr_en,
  input  logic                          cfg_rx_en,
  input  logic [5:0]                    cfg_prescale,
  input  logic                          cfg_par_en,
  input  logic                          cfg_par_typ,
  input  logic                          rx_busy,
  input  logic                          rx_done,
  input  logic                          rx_data_valid,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  input  logic                          rx_par_err,
  input  logic                          rx_stp_err,
  output logic                          core_en,
  output logic [5:0]                    core_prescale,
  output logic                          core_par_en,
  output logic                          core_par_typ,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  input  logic                          err_clr,
  output logic                          ovf_err,
  output logic                          par_err_flag,
  output logic                          stp_err_flag,
  output logic                          cfg_err,
  output logic [15:0]                   frame_cnt,
  output logic                          irq
);

  import uart_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  rx_state_e state_q, state_d;
  rx_cfg_t   act_q, act_d, pend_q, pend_d, wr_cfg;
  logic      wr_ok;

  assign wr_cfg = '{en: cfg_rx_en, prescale: cfg_prescale,
                    par_en: cfg_par_en, par_typ: cfg_par_typ};
  // An illegal prescale discards the whole write.
  assign wr_ok  = cfg_wr_en && (cfg_prescale >= 6'(PRESCALE_MIN));

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_OFF, S_IDLE: begin
        if (wr_ok) begin
          act_d   = wr_cfg;
          state_d = !wr_cfg.en ? S_OFF : (rx_busy ? S_FRAME : S_IDLE);
        end else if (state_q == S_IDLE && rx_busy) begin
          state_d = S_FRAME;
        end
      end
      S_FRAME: begin
        if (!rx_busy) begin
          if (wr_ok) act_d = wr_cfg;
          state_d = act_d.en ? S_IDLE : S_OFF;
        end else if (wr_ok) begin
          pend_d  = wr_cfg;
          state_d = S_PEND;
        end
      end
      S_PEND: begin
        if (!rx_busy) begin
          act_d   = wr_ok ? wr_cfg : pend_q;
          state_d = act_d.en ? S_IDLE : S_OFF;
        end else if (wr_ok) begin
          pend_d = wr_cfg;
        end
      end
      default: state_d = S_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_OFF;
      act_q   <= '{en: 1'b0, prescale: 6'(PRESCALE_DEF), par_en: 1'b0, par_typ: 1'b0};
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      pend_q  <= pend_d;
    end
  end

  assign core_en       = (state_q != S_OFF);
  assign core_prescale = act_q.prescale;
  assign core_par_en   = act_q.par_en;
  assign core_par_typ  = act_q.par_typ;

  logic          fifo_full, fifo_empty, push_ok;
  logic [CW-1:0] cnt_next;

  uart_rx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rx_data_valid),
    .pop      (rd_en),
    .wr_data  (rx_data),
    .rd_data  (rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .push_ok  (push_ok),
    .cnt      (fifo_cnt),
    .cnt_next (cnt_next)
  );

  assign rd_valid = !fifo_empty;

  logic ovf_set, par_set, stp_set, cfg_set;
  logic ovf_d, par_d, stp_d, cfg_d, irq_d;

  assign ovf_set = rx_data_valid && fifo_full && !(rd_en && !fifo_empty);
  assign par_set = rx_done && rx_par_err;
  assign stp_set = rx_done && rx_stp_err;
  assign cfg_set = cfg_wr_en && !wr_ok;

  // A set in the same cycle as err_clr wins.
  always_comb begin
    ovf_d = ovf_set | (ovf_err & ~err_clr);
    par_d = par_set | (par_err_flag & ~err_clr);
    stp_d = stp_set | (stp_err_flag & ~err_clr);
    cfg_d = cfg_set | (cfg_err & ~err_clr);
    irq_d = (cnt_next >= CW'(IRQ_THRESH)) | ovf_d | par_d | stp_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err      <= 1'b0;
      par_err_flag <= 1'b0;
      stp_err_flag <= 1'b0;
      cfg_err      <= 1'b0;
      frame_cnt    <= '0;
      irq          <= 1'b0;
    end else begin
      ovf_err      <= ovf_d;
      par_err_flag <= par_d;
      stp_err_flag <= stp_d;
      cfg_err      <= cfg_d;
      irq          <= irq_d;
      if (push_ok) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Control and buffering wrapper for the UART receive core. Holds the active RX configuration (prescale, parity enable/type, receiver enable) and applies host writes only on frame boundaries, so a frame in flight is never corrupted. Buffers good bytes in a small show-ahead FIFO. Keeps sticky error flags and drives a level interrupt to the SoC peripheral bus.

Parameters:
DATA_WIDTH, 8, received byte width
FIFO_DEPTH, 8, entries in the RX buffer (power of two, >=2)
PRESCALE_DEF, 8, core prescale after reset
IRQ_THRESH, 1, FIFO fill level at or above which irq asserts

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
cfg_wr_en  in  1  one-cycle config write strobe
cfg_rx_en  in  1  requested receiver enable
cfg_prescale  in  6  requested oversampling prescale
cfg_par_en  in  1  requested parity enable
cfg_par_typ  in  1  requested parity type (0 even, 1 odd)
rx_busy  in  1  core frame in progress (core FSM not idle)
rx_done  in  1  one-cycle end-of-frame check pulse from core
rx_data_valid  in  1  one-cycle good-byte pulse from core
rx_data  in  DATA_WIDTH  byte from core deserializer
rx_par_err  in  1  parity error, qualified by rx_done
rx_stp_err  in  1  stop error, qualified by rx_done
core_en  out  1  receiver enable to core
core_prescale  out  6  active prescale to core
core_par_en  out  1  active parity enable to core
core_par_typ  out  1  active parity type to core
rd_en  in  1  host pop request
rd_data  out  DATA_WIDTH  FIFO head (show-ahead)
rd_valid  out  1  FIFO not empty
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current fill level
err_clr  in  1  clear all sticky error flags
ovf_err  out  1  sticky: byte dropped on full FIFO
par_err_flag  out  1  sticky parity error
stp_err_flag  out  1  sticky stop error
cfg_err  out  1  sticky: illegal prescale write rejected
frame_cnt  out  16  count of accepted bytes, wraps 0xFFFF->0
irq  out  1  registered interrupt

Behaviour:
- Reset (async, rst=1): state S_OFF; core_en=0, core_prescale=PRESCALE_DEF, core_par_en=0, core_par_typ=0; FIFO empty (rd_valid=0, fifo_cnt=0); all sticky flags 0; frame_cnt=0; irq=0. Reset asserted mid-frame discards the FIFO and any pending config.
- Config FSM states:
  - S_OFF: core_en=0. cfg_wr_en applies all fields on the next edge; goes to S_IDLE if cfg_rx_en=1.
  - S_IDLE: core_en=1. cfg_wr_en applies on the next edge (S_OFF if cfg_rx_en=0). Goes to S_FRAME when rx_busy=1.
  - S_FRAME: a cfg_wr_en is latched into pending registers and the FSM moves to S_PEND. Returns to S_IDLE when rx_busy=0.
  - S_PEND: a further cfg_wr_en overwrites pending (last write wins). When rx_busy=0, pending is applied on that edge and the FSM goes to S_IDLE or S_OFF per pending rx_en.
- Prescale validity: cfg_prescale < 4 is illegal. The whole write is ignored (no state or pending change) and cfg_err sets.
- FIFO:
  - Push on rx_data_valid. Pop on rd_en && rd_valid. Pop when empty is ignored.
  - Full with push and no pop: byte dropped, ovf_err set, frame_cnt not incremented.
  - Full with push and pop in the same cycle: both occur, count unchanged, no overflow.
  - Empty with push and pop in the same cycle: pop ignored, push occurs.
  - rd_data is valid combinationally from the head entry. Pointers wrap modulo FIFO_DEPTH.
- frame_cnt increments on every successful push.
- Sticky errors:
  - rx_done && rx_par_err sets par_err_flag; rx_done && rx_stp_err sets stp_err_flag.
  - err_clr clears ovf_err, par_err_flag, stp_err_flag and cfg_err. A set in the same cycle wins over clear.
- irq is registered: irq <= (fifo_cnt_next >= IRQ_THRESH) | ovf_err | par_err_flag | stp_err_flag, with the flags taken as their next-cycle values. It asserts one cycle after the causing event.
- Disabling while idle takes effect next edge. Disabling mid-frame completes the frame, buffering the byte if good. FIFO contents survive disable.

Decomposition:
- Shared uart_pkg: state encodings (S_OFF, S_IDLE, S_FRAME, S_PEND), PRESCALE_MIN=4, PRESCALE_DEF.
- One sub-module: uart_rx_fifo (show-ahead sync FIFO with push, pop, full, empty and count). Config FSM, sticky flags and irq stay in uart_rx_ctrl.

Test Plan:
- Reset, write cfg {en=1, prescale=16, par_en=1, typ=1} -> next cycle core_en=1, core_prescale=16, core_par_en=1, core_par_typ=1; state S_IDLE.
- rx_busy=1, then write prescale=32 mid-frame -> core_prescale stays 16 until rx_busy falls, then becomes 32 on that edge; second write of 8 while pending -> 8 applied instead.
- Push 0xA5, 0x3C -> rd_data=0xA5, fifo_cnt=2, irq=1 one cycle after first push; pop -> rd_data=0x3C; pop -> rd_valid=0, irq=0.
- Fill 8 entries, push 0x11 -> dropped, ovf_err=1, frame_cnt=8; push+pop same cycle when full -> fifo_cnt stays 8, ovf_err unchanged.
- rx_done with rx_par_err=1 and err_clr=1 same cycle -> par_err_flag=1; err_clr next cycle -> flag 0.
- Write prescale=2 -> config unchanged, cfg_err=1; assert rst mid-frame with 3 bytes queued -> all outputs at reset values.
